// File: rtl/dac_pattern_player.sv
// AXI4-Stream pattern source: replays beats 0..last from a 96-bit pattern RAM
// toward a DAC, one-shot or looping, through a 2-entry skid FIFO.
module dac_pattern_player #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 wr_en_i,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  logic [95:0]          wr_data_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 loop_i,
  input  logic [ADDR_BITS-1:0] last_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [127:0]         dac_tdata,
  output logic                 dac_tvalid,
  input  logic                 dac_tready
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_ABORT = 2'd3;
  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [1:0]           state_reg, state_next;
  logic [ADDR_BITS-1:0] rd_addr_reg, rd_addr_next;
  logic [ADDR_BITS-1:0] last_reg;
  logic                 loop_reg;
  logic                 rd_valid_reg;
  logic                 done_reg, done_next;
  logic [95:0]          mem [DEPTH];
  logic [95:0]          rd_data_reg;
  logic [127:0]         fifo_data_reg [2];
  logic                 wr_ptr_reg, rd_ptr_reg;
  logic [1:0]           count_reg;
  logic [127:0]         packed_beat;
  logic [2:0]           occupancy;
  logic                 accept, rd_en, push, pop, flush, room;

  // Left-justify each 12-bit sample into its 16-bit lane; low nibble is zero.
  for (genvar gi = 0; gi < 8; gi++) begin : g_pack
    assign packed_beat[16*gi +: 16] = {rd_data_reg[12*gi +: 12], 4'b0000};
  end

  assign dac_tvalid = (count_reg != 2'd0);
  assign dac_tdata  = fifo_data_reg[rd_ptr_reg];
  assign pop        = dac_tvalid & dac_tready;
  assign busy_o     = (state_reg != ST_IDLE);
  assign done_o     = done_reg;
  assign accept     = (state_reg == ST_IDLE) && start_i && !stop_i;

  // Entries left after this cycle's pop plus the read already in flight; one
  // more read may be issued only if that sum leaves a free slot.
  assign occupancy = {1'b0, count_reg} + {2'b00, rd_valid_reg} - {2'b00, pop};
  assign room      = (occupancy < 3'd2);

  always_comb begin
    state_next   = state_reg;
    rd_addr_next = rd_addr_reg;
    rd_en        = 1'b0;
    flush        = 1'b0;
    done_next    = 1'b0;
    push         = rd_valid_reg && !stop_i &&
                   ((state_reg == ST_PLAY) || (state_reg == ST_DRAIN));
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next   = ST_PLAY;
          rd_addr_next = '0;
        end
      end
      ST_PLAY: begin
        if (stop_i) begin
          state_next = ST_ABORT;
        end else if (room) begin
          rd_en = 1'b1;
          if (rd_addr_reg == last_reg) begin
            rd_addr_next = '0;
            if (!loop_reg) state_next = ST_DRAIN;
          end else begin
            rd_addr_next = rd_addr_reg + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (stop_i) begin
          state_next = ST_ABORT;
        end else if (pop && (count_reg == 2'd1) && !rd_valid_reg) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        // The presented beat must complete; everything behind it is dropped.
        if (dac_tvalid) begin
          if (pop) begin
            flush      = 1'b1;
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end else if (!rd_valid_reg) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg    <= ST_IDLE;
      rd_addr_reg  <= '0;
      last_reg     <= '0;
      loop_reg     <= 1'b0;
      rd_valid_reg <= 1'b0;
      done_reg     <= 1'b0;
      count_reg    <= 2'd0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      for (int i = 0; i < 2; i++) fifo_data_reg[i] <= '0;
    end else begin
      state_reg    <= state_next;
      rd_addr_reg  <= rd_addr_next;
      rd_valid_reg <= rd_en;
      done_reg     <= done_next;
      if (accept) begin
        loop_reg <= loop_i;
        last_reg <= last_i;
      end
      if (flush) begin
        count_reg  <= 2'd0;
        wr_ptr_reg <= 1'b0;
        rd_ptr_reg <= 1'b0;
      end else begin
        if (push) begin
          fifo_data_reg[wr_ptr_reg] <= packed_beat;
          wr_ptr_reg                <= ~wr_ptr_reg;
        end
        if (pop) rd_ptr_reg <= ~rd_ptr_reg;
        count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  // Pattern RAM: read-first, registered read, contents survive reset.
  always_ff @(posedge aclk) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
    if (rd_en) rd_data_reg <= mem[rd_addr_reg];
  end

endmodule

// File: tb/tb_dac_pattern_player.sv
// Directed/randomized bench for dac_pattern_player; every handshaked beat is
// checked against a beat-index model of the pattern memory.
module tb_dac_pattern_player;
  localparam int AB = 10;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          wr_en_i = 1'b0;
  logic [AB-1:0] wr_addr_i = '0;
  logic [95:0]   wr_data_i = '0;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic          loop_i = 1'b0;
  logic [AB-1:0] last_i = '0;
  logic          busy_o, done_o, dac_tvalid;
  logic [127:0]  dac_tdata;
  logic          dac_tready = 1'b0;

  dac_pattern_player #(.ADDR_BITS(AB)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .start_i(start_i), .stop_i(stop_i), .loop_i(loop_i), .last_i(last_i),
    .busy_o(busy_o), .done_o(done_o),
    .dac_tdata(dac_tdata), .dac_tvalid(dac_tvalid), .dac_tready(dac_tready)
  );

  always #5 aclk = ~aclk;

  int tests = 0, fails = 0;
  logic [95:0] model_mem [0:1023];
  int cur_last = 0, rx_count = 0, done_cnt = 0, cycle = 0;
  int done_cycle = 0, last_hs_cycle = 0;
  bit cur_loop = 1'b0, prev_stall = 1'b0;
  logic [127:0] prev_data = '0, first_beat = '0, exp_beat;

  function automatic logic [127:0] pack(input logic [95:0] w);
    logic [127:0] r = '0;
    for (int i = 0; i < 8; i++) r = r | (128'(w[12*i +: 12]) << (16*i + 4));
    return r;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++; $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++; $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_data(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++; $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Observe the current cycle (inputs already driven), then advance one clock.
  task automatic step();
    if (aresetn) begin
      if (prev_stall) begin
        chk1("hold_valid", dac_tvalid, 1'b1);
        chk_data("hold_data", dac_tdata, prev_data);
      end
      if (dac_tvalid && dac_tready) begin
        if (!cur_loop) chk1("beat_in_range", rx_count <= cur_last, 1'b1);
        exp_beat = pack(model_mem[10'(rx_count % (cur_last + 1))]);
        chk_data("beat_data", dac_tdata, exp_beat);
        if (rx_count == 0) first_beat = dac_tdata;
        rx_count++;
        last_hs_cycle = cycle;
      end
      if (done_o) begin
        done_cnt++;
        done_cycle = cycle;
        chk1("busy_at_done", busy_o, 1'b0);
      end
      prev_stall = dac_tvalid && !dac_tready;
      prev_data  = dac_tdata;
    end
    @(negedge aclk);
    cycle++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input int addr, input logic [95:0] data);
    wr_en_i = 1'b1; wr_addr_i = AB'(addr); wr_data_i = data;
    model_mem[10'(addr)] = data;
    step();
    wr_en_i = 1'b0;
  endtask

  task automatic start_play(input bit lp, input int last);
    loop_i = lp; last_i = AB'(last); start_i = 1'b1;
    cur_loop = lp; cur_last = last; rx_count = 0;
    step();
    start_i = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input bit rand_ready, input string tag);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      if (rand_ready) dac_tready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    chk1(tag, done_cnt != d0, 1'b1);
  endtask

  initial begin
    int d0, rx0, len;
    logic [95:0] w;

    // Reset values
    @(negedge aclk);
    chk1("rst_tvalid", dac_tvalid, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_done", done_o, 1'b0);
    chk_data("rst_tdata", dac_tdata, 128'd0);
    steps(2);
    aresetn = 1'b1;
    step();

    // Pattern load: beats 0..3 ramp, the rest random
    for (int b = 0; b < 64; b++) begin
      for (int i = 0; i < 8; i++)
        w[12*i +: 12] = (b < 4) ? 12'(256 * (b + 1) + i) : 12'($urandom);
      wr(b, w);
    end

    // One-shot, last=3, no backpressure, with start latency
    dac_tready = 1'b1;
    d0 = done_cnt;
    start_play(1'b0, 3);
    chk1("t1_busy_after_start", busy_o, 1'b1);
    chk1("t1_no_valid_n0", dac_tvalid, 1'b0);
    step();
    chk1("t1_no_valid_n1", dac_tvalid, 1'b0);
    step();
    chk1("t1_valid_n2", dac_tvalid, 1'b1);
    run_until_done(20, 1'b0, "t1_done");
    chk_int("t1_beats", rx_count, 4);
    chk_int("t1_lane0", int'(first_beat[15:0]), 'h1000);
    chk_int("t1_lane7", int'(first_beat[127:112]), 'h1070);
    chk_int("t1_done_latency", done_cycle - last_hs_cycle, 1);
    steps(3);
    chk1("t1_idle_valid", dac_tvalid, 1'b0);
    chk_int("t1_done_once", done_cnt - d0, 1);

    // Continuous, last=2: one beat per cycle across the wrap
    start_play(1'b1, 2);
    steps(2);
    for (int c = 0; c < 20; c++) begin
      chk1("t2_sustained", dac_tvalid, 1'b1);
      step();
    end
    chk_int("t2_beats", rx_count, 20);
    stop_i = 1'b1; step(); stop_i = 1'b0;
    run_until_done(10, 1'b0, "t2_stop_done");
    step();
    chk1("t2_idle_busy", busy_o, 1'b0);

    // One-shot, last=15, random backpressure
    start_play(1'b0, 15);
    run_until_done(400, 1'b1, "t3_done");
    chk_int("t3_beats", rx_count, 16);
    dac_tready = 1'b1;

    // Stop while a beat is stalled: exactly that beat transfers
    start_play(1'b1, 5);
    steps(6);
    dac_tready = 1'b0;
    steps(4);
    chk1("t4_pending", dac_tvalid, 1'b1);
    stop_i = 1'b1; step(); stop_i = 1'b0;
    rx0 = rx_count; d0 = done_cnt;
    steps(3);
    chk_int("t4_no_early_done", done_cnt - d0, 0);
    chk1("t4_busy_hold", busy_o, 1'b1);
    dac_tready = 1'b1;
    run_until_done(10, 1'b0, "t4_done");
    chk_int("t4_one_beat", rx_count - rx0, 1);
    step();
    chk1("t4_idle_valid", dac_tvalid, 1'b0);
    chk1("t4_idle_busy", busy_o, 1'b0);

    // start+stop together in IDLE, then start during PLAY: both ignored
    d0 = done_cnt;
    loop_i = 1'b1; last_i = AB'(3); start_i = 1'b1; stop_i = 1'b1;
    step();
    start_i = 1'b0; stop_i = 1'b0;
    chk1("t5_ignored_busy", busy_o, 1'b0);
    steps(3);
    chk_int("t5_no_done", done_cnt - d0, 0);
    chk1("t5_no_valid", dac_tvalid, 1'b0);
    start_play(1'b0, 7);
    steps(4);
    loop_i = 1'b1; last_i = AB'(2); start_i = 1'b1;
    step();
    start_i = 1'b0;
    run_until_done(50, 1'b0, "t5_done");
    chk_int("t5_beats", rx_count, 8);

    // Reset mid-playback, then replay from retained memory
    start_play(1'b1, 4);
    steps(6);
    aresetn = 1'b0;
    #1;
    chk1("t6_rst_valid", dac_tvalid, 1'b0);
    chk1("t6_rst_busy", busy_o, 1'b0);
    chk1("t6_rst_done", done_o, 1'b0);
    prev_stall = 1'b0;
    steps(2);
    aresetn = 1'b1;
    step();
    start_play(1'b0, 4);
    run_until_done(20, 1'b0, "t6_done");
    chk_int("t6_beats", rx_count, 5);

    // Continuous with last=0: every beat is beat 0
    start_play(1'b1, 0);
    for (int c = 0; c < 30; c++) begin
      dac_tready = 1'($urandom_range(0, 1));
      step();
    end
    stop_i = 1'b1; step(); stop_i = 1'b0;
    run_until_done(20, 1'b1, "t7_stop_done");
    chk1("t7_some_beats", rx_count > 0, 1'b1);

    // Randomized one-shot runs, including last=0
    for (int k = 0; k < 4; k++) begin
      len = (k == 0) ? 0 : int'($urandom_range(1, 40));
      start_play(1'b0, len);
      run_until_done(600, 1'b1, "t8_done");
      chk_int("t8_beats", rx_count, len + 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
